// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: time-multiplexed driver for a common-anode 7-segment display fed by
// packed BCD (digit 0 = units in dec_in[3:0]).
//
// One digit is lit at a time, each for PRESCALE clocks. The BCD word is snapshotted
// once per frame, on the last tick of the final digit, so a word changing mid-scan
// never shows a mix of old and new digits. Leading zeros can be blanked, and a nibble
// above 9 is drawn as 'E' and raises bcd_err.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   dec_in     in   [DWIDTH-1:0] packed BCD, nibble k = digit k (sampled only at snapshot)
//   blank_lz   in   1: blank leading zeros (digit 0 never blanked), sampled live
//   seg        out  [6:0] segments {g,f,e,d,c,b,a}, active-low when SEG_ACT_LO
//   an         out  [NDIG-1:0] one-hot digit enable, active-low when AN_ACT_LO
//   frame_tick out  1-cycle pulse when the snapshot is loaded
//   bcd_err    out  high while any snapshot nibble is above 9
//
// DWIDTH must equal 4*NDIG; PRESCALE must be at least 2. All outputs are registered.

module bcd_seg_scan #(
    parameter int unsigned NDIG       = 4,
    parameter int unsigned DWIDTH     = 16,
    parameter int unsigned PRESCALE   = 50000,
    parameter bit          SEG_ACT_LO = 1'b1,
    parameter bit          AN_ACT_LO  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] dec_in,
    input  logic              blank_lz,
    output logic [6:0]        seg,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick,
    output logic              bcd_err
);

    localparam int unsigned PW    = $clog2(PRESCALE);
    localparam int unsigned DIG_W = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [PW-1:0]    PCNT_LAST = PW'(PRESCALE - 1);
    localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(NDIG - 1);

    // Inactive output levels, used at reset and for blanked digits.
    localparam logic [6:0]      SEG_OFF = SEG_ACT_LO ? 7'h7F : 7'h00;
    localparam logic [NDIG-1:0] AN_OFF  = AN_ACT_LO ? {NDIG{1'b1}} : {NDIG{1'b0}};

    // Active-high decode of one nibble; A..F draws 'E'.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h79;
        endcase
        return s;
    endfunction

    logic [PW-1:0]     pcnt_q, pcnt_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [DWIDTH-1:0] dec_q, dec_d;
    logic [6:0]        seg_q, seg_d;
    logic [NDIG-1:0]   an_q, an_d;
    logic              frame_tick_q, frame_tick_d;
    logic              bcd_err_q, bcd_err_d;

    logic              tick;
    logic              last_dig;
    logic [NDIG-1:0]   lead_zero;   // lead_zero[k]: nibbles NDIG-1..k of dec_q all zero
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic [NDIG-1:0]   cur_onehot;
    logic              nz_seen;
    logic [6:0]        seg_act;
    logic [NDIG-1:0]   an_act;

    // Prescaler, digit scan and snapshot control.
    always_comb begin
        tick         = (pcnt_q == PCNT_LAST);
        last_dig     = (dig_q == DIG_LAST);
        pcnt_d       = tick ? '0 : pcnt_q + 1'b1;
        dig_d        = dig_q;
        dec_d        = dec_q;
        frame_tick_d = 1'b0;
        if (tick) begin
            dig_d = last_dig ? '0 : dig_q + 1'b1;
            if (last_dig) begin
                dec_d        = dec_in;
                frame_tick_d = 1'b1;
            end
        end
    end

    // Display path: everything here is a function of registered state plus blank_lz,
    // and lands in output registers, so there is no input-to-output combinational path.
    always_comb begin
        nz_seen    = 1'b0;
        lead_zero  = '0;
        cur_nib    = '0;
        cur_blank  = 1'b0;
        cur_onehot = '0;
        bcd_err_d  = 1'b0;
        // Scan from the most significant digit down; an invalid nibble is nonzero too.
        for (int k = NDIG - 1; k >= 0; k--) begin
            nz_seen      = nz_seen | (dec_q[4*k +: 4] != 4'd0);
            lead_zero[k] = ~nz_seen;
        end
        for (int k = 0; k < NDIG; k++) begin
            bcd_err_d = bcd_err_d | (dec_q[4*k +: 4] > 4'd9);
            if (dig_q == DIG_W'(k)) begin
                cur_nib       = dec_q[4*k +: 4];
                cur_onehot[k] = 1'b1;
                cur_blank     = blank_lz && (k != 0) && lead_zero[k];
            end
        end
        seg_act = cur_blank ? 7'h00 : seg_decode(cur_nib);
        an_act  = cur_blank ? '0 : cur_onehot;
        seg_d   = SEG_ACT_LO ? ~seg_act : seg_act;
        an_d    = AN_ACT_LO ? ~an_act : an_act;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q       <= '0;
            dig_q        <= '0;
            dec_q        <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
            bcd_err_q    <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            dig_q        <= dig_d;
            dec_q        <= dec_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
            bcd_err_q    <= bcd_err_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;
    assign bcd_err    = bcd_err_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Bench for bcd_seg_scan (NDIG=4, PRESCALE=4, active-low seg and an).
// The stimulus process issues one vector per frame and queues the hand-computed
// display for that frame; the monitor pops an entry at each frame_tick and checks
// every cycle of the following frame.

module tb_bcd_seg_scan;

    localparam int unsigned NDIG     = 4;
    localparam int unsigned DWIDTH   = 16;
    localparam int unsigned PRESCALE = 4;
    localparam int          NVEC     = 7;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DWIDTH-1:0] dec_in = '0;
    logic              blank_lz = 1'b0;
    logic [6:0]        seg;
    logic [NDIG-1:0]   an;
    logic              frame_tick;
    logic              bcd_err;

    bcd_seg_scan #(
        .NDIG      (NDIG),
        .DWIDTH    (DWIDTH),
        .PRESCALE  (PRESCALE),
        .SEG_ACT_LO(1'b1),
        .AN_ACT_LO (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_in    (dec_in),
        .blank_lz  (blank_lz),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick),
        .bcd_err   (bcd_err)
    );

    always #5 clk = ~clk;

    // Expected display for one frame: seg packed {d3,d2,d1,d0}, an packed {d3,d2,d1,d0}.
    typedef struct packed {
        logic [27:0] seg;
        logic [15:0] an;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    logic [15:0] vec_dec [NVEC+1];
    logic        vec_blz [NVEC];
    logic [27:0] vec_seg [NVEC];
    logic [15:0] vec_an  [NVEC];
    logic        vec_err [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Waits (at negedges) for frame_tick, at most 100 cycles.
    task automatic wait_frame(output bit ok);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (frame_tick === 1'b1);
    endtask

    initial begin
        bit   ok;
        exp_t e;

        vec_dec = '{16'h0243, 16'h0243, 16'h0011, 16'h0011, 16'h00A0, 16'h0000, 16'hF9B8,
                    16'h0243};
        vec_blz = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        vec_seg = '{{7'h7F, 7'h24, 7'h19, 7'h30},
                    {7'h40, 7'h24, 7'h19, 7'h30},
                    {7'h40, 7'h40, 7'h79, 7'h79},
                    {7'h7F, 7'h7F, 7'h79, 7'h79},
                    {7'h7F, 7'h7F, 7'h06, 7'h40},
                    {7'h7F, 7'h7F, 7'h7F, 7'h40},
                    {7'h06, 7'h10, 7'h06, 7'h00}};
        vec_an  = '{16'hFBDE, 16'h7BDE, 16'h7BDE, 16'hFFDE, 16'hFFDE, 16'hFFFE, 16'h7BDE};
        vec_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

        // Reset state; dec_in already nonzero to show reset does not snapshot.
        dec_in   = vec_dec[0];
        blank_lz = vec_blz[0];
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset seg", 32'(seg), 32'h7F);
        check("reset an", 32'(an), 32'hF);
        check("reset frame_tick", 32'(frame_tick), 32'h0);
        check("reset bcd_err", 32'(bcd_err), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post-reset digit0", 32'({seg, an}), 32'({7'h40, 4'hE}));

        fork
            // Stimulus: at each frame start, set blank_lz for this frame, queue its
            // expected display, park junk on dec_in, then load the next word mid-frame.
            begin
                for (int i = 0; i < NVEC; i++) begin
                    wait_frame(ok);
                    if (!ok) begin
                        check("stim frame_tick timeout", 32'd0, 32'd1);
                        break;
                    end
                    blank_lz = vec_blz[i];
                    e.seg = vec_seg[i];
                    e.an  = vec_an[i];
                    e.err = vec_err[i];
                    sb_q.push_back(e);
                    dec_in = 16'h9999;
                    repeat (6) @(negedge clk);
                    dec_in = vec_dec[i+1];
                end
            end
            // Monitor
            begin
                exp_t m;
                for (int f = 0; f < NVEC; f++) begin
                    wait_frame(ok);
                    if (!ok) begin
                        check("monitor frame_tick timeout", 32'd0, 32'd1);
                        break;
                    end
                    @(negedge clk);
                    if (sb_q.size() == 0) begin
                        check("scoreboard empty at frame", 32'd0, 32'd1);
                        break;
                    end
                    m = sb_q.pop_front();
                    check($sformatf("frame%0d frame_tick width", f), 32'(frame_tick), 32'h0);
                    check($sformatf("frame%0d bcd_err", f), 32'(bcd_err), 32'(m.err));
                    for (int d = 0; d < 4; d++) begin
                        for (int c = 0; c < PRESCALE; c++) begin
                            if (d != 0 || c != 0) @(negedge clk);
                            check($sformatf("frame%0d digit%0d cycle%0d {seg,an}", f, d, c),
                                  32'({seg, an}), 32'({m.seg[7*d +: 7], m.an[4*d +: 4]}));
                        end
                    end
                end
            end
        join

        // Reset during digit 2 of a frame holding 0x0243.
        blank_lz = 1'b0;
        repeat (9) @(negedge clk);
        check("pre-reset digit2", 32'({seg, an}), 32'({7'h24, 4'hB}));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-frame reset seg", 32'(seg), 32'h7F);
        check("mid-frame reset an", 32'(an), 32'hF);
        check("mid-frame reset frame_tick", 32'(frame_tick), 32'h0);
        check("mid-frame reset bcd_err", 32'(bcd_err), 32'h0);
        @(negedge clk);
        check("after reset digit0 cleared", 32'({seg, an}), 32'({7'h40, 4'hE}));
        repeat (4) @(negedge clk);
        check("after reset digit1 cleared", 32'({seg, an}), 32'({7'h40, 4'hD}));
        wait_frame(ok);
        check("frame_tick after reset", 32'(ok), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
